pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/rv_pipe_pkg.sv | 42 ++++
 rtl/load_use_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline-control definitions: controller state encoding, divider latency
// and the bundle of pipeline-register controls produced by the hazard unit.
package rv_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    localparam int DIV_CYCLES = 32;
    localparam int DIV_CNT_W  = $clog2(DIV_CYCLES);
    localparam logic [DIV_CNT_W-1:0] DIV_CNT_INIT = DIV_CNT_W'(DIV_CYCLES - 1);

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_ma_en;
        logic ma_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_ma_flush;
        logic ma_wb_flush;
        logic div_start;
    } ctrl_t;

    localparam ctrl_t CTRL_NORMAL = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                      ex_ma_en: 1'b1, ma_wb_en: 1'b1, default: 1'b0};
    // Whole front end frozen; only the MA->WB stage moves, carrying a bubble.
    localparam ctrl_t CTRL_MEM = '{ma_wb_en: 1'b1, ma_wb_flush: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_DIV_HOLD = '{ex_ma_en: 1'b1, ma_wb_en: 1'b1,
                                        ex_ma_flush: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_DIV_START = '{ex_ma_en: 1'b1, ma_wb_en: 1'b1,
                                         ex_ma_flush: 1'b1, div_start: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1,
                                      ex_ma_en: 1'b1, ma_wb_en: 1'b1, if_id_flush: 1'b1,
                                      id_ex_flush: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_LOAD_USE = '{id_ex_en: 1'b1, ex_ma_en: 1'b1, ma_wb_en: 1'b1,
                                        id_ex_flush: 1'b1, default: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic [1:0] ex_mr,
    input  logic       ex_reg_en,
    output logic       load_use
);

    logic ex_is_load_wr;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign ex_is_load_wr = (ex_mr != 2'd0) && ex_reg_en && (ex_rd != 5'd0);

    assign load_use = ex_is_load_wr &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: prioritises memory, divide, branch and load-use
// hazards into register enables/flushes, and sequences the multi-cycle divide.
module pipeline_hazard_ctrl (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_RS1,
    input  logic [4:0]  ID_RS2,
    input  logic        ID_USES_RS1,
    input  logic        ID_USES_RS2,
    input  logic [4:0]  EX_RD,
    input  logic [1:0]  EX_MR,
    input  logic        EX_REG_EN,
    input  logic        EX_BRANCH_TAKEN,
    input  logic        EX_IS_DIV,
    input  logic        MA_MEM_REQ,
    input  logic        MEM_READY,
    output logic        PC_EN,
    output logic        IF_ID_EN,
    output logic        ID_EX_EN,
    output logic        EX_MA_EN,
    output logic        MA_WB_EN,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_FLUSH,
    output logic        EX_MA_FLUSH,
    output logic        MA_WB_FLUSH,
    output logic        DIV_START,
    output logic [1:0]  STATE,
    output logic [31:0] STALL_CNT
);

    import rv_pipe_pkg::*;

    state_e                 state_q, state_d;
    logic [DIV_CNT_W-1:0]   div_cnt_q, div_cnt_d;
    logic [31:0]            stall_cnt_q, stall_cnt_d;
    logic                   mem_stall;
    logic                   load_use;
    ctrl_t                  ctrl;

    load_use_detect u_load_use_detect (
        .id_rs1      (ID_RS1),
        .id_rs2      (ID_RS2),
        .id_uses_rs1 (ID_USES_RS1),
        .id_uses_rs2 (ID_USES_RS2),
        .ex_rd       (EX_RD),
        .ex_mr       (EX_MR),
        .ex_reg_en   (EX_REG_EN),
        .load_use    (load_use)
    );

    assign mem_stall = MA_MEM_REQ && !MEM_READY;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        ctrl      = CTRL_NORMAL;
        state_d   = state_q;
        div_cnt_d = div_cnt_q;

        case (state_q)
            ST_DIV_WAIT: begin
                // The divider keeps counting through memory stalls; only capture waits.
                if (div_cnt_q != '0) begin
                    div_cnt_d = div_cnt_q - DIV_CNT_W'(1);
                    ctrl      = mem_stall ? CTRL_MEM : CTRL_DIV_HOLD;
                end else if (mem_stall) begin
                    ctrl = CTRL_MEM;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // MEM_WAIT with memory ready decodes exactly like RUN.
                if (mem_stall) begin
                    ctrl    = CTRL_MEM;
                    state_d = ST_MEM_WAIT;
                end else if (EX_IS_DIV) begin
                    ctrl      = CTRL_DIV_START;
                    state_d   = ST_DIV_WAIT;
                    div_cnt_d = DIV_CNT_INIT;
                end else begin
                    state_d = ST_RUN;
                    if (EX_BRANCH_TAKEN) begin
                        ctrl = CTRL_BRANCH;
                    end else if (load_use) begin
                        ctrl = CTRL_LOAD_USE;
                    end
                end
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_RUN;
            div_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign PC_EN       = ctrl.pc_en;
    assign IF_ID_EN    = ctrl.if_id_en;
    assign ID_EX_EN    = ctrl.id_ex_en;
    assign EX_MA_EN    = ctrl.ex_ma_en;
    assign MA_WB_EN    = ctrl.ma_wb_en;
    assign IF_ID_FLUSH = ctrl.if_id_flush;
    assign ID_EX_FLUSH = ctrl.id_ex_flush;
    assign EX_MA_FLUSH = ctrl.ex_ma_flush;
    assign MA_WB_FLUSH = ctrl.ma_wb_flush;
    assign DIV_START   = ctrl.div_start;
    assign STATE       = state_q;
    assign STALL_CNT   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// traffic, all compared every cycle against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  ID_RS1, ID_RS2, EX_RD;
    logic        ID_USES_RS1, ID_USES_RS2;
    logic [1:0]  EX_MR;
    logic        EX_REG_EN, EX_BRANCH_TAKEN, EX_IS_DIV, MA_MEM_REQ, MEM_READY;
    logic        PC_EN, IF_ID_EN, ID_EX_EN, EX_MA_EN, MA_WB_EN;
    logic        IF_ID_FLUSH, ID_EX_FLUSH, EX_MA_FLUSH, MA_WB_FLUSH, DIV_START;
    logic [1:0]  STATE;
    logic [31:0] STALL_CNT;

    pipeline_hazard_ctrl dut (
        .CLK(CLK), .RESET(RESET),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .EX_RD(EX_RD), .EX_MR(EX_MR), .EX_REG_EN(EX_REG_EN),
        .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .EX_IS_DIV(EX_IS_DIV),
        .MA_MEM_REQ(MA_MEM_REQ), .MEM_READY(MEM_READY),
        .PC_EN(PC_EN), .IF_ID_EN(IF_ID_EN), .ID_EX_EN(ID_EX_EN),
        .EX_MA_EN(EX_MA_EN), .MA_WB_EN(MA_WB_EN),
        .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
        .EX_MA_FLUSH(EX_MA_FLUSH), .MA_WB_FLUSH(MA_WB_FLUSH),
        .DIV_START(DIV_START), .STATE(STATE), .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    // {PC, IF_ID, ID_EX, EX_MA, MA_WB enables, IF_ID, ID_EX, EX_MA, MA_WB flushes, DIV_START}
    localparam logic [9:0] C_NORM = 10'b11111_0000_0;
    localparam logic [9:0] C_MEM  = 10'b00001_0001_0;
    localparam logic [9:0] C_HOLD = 10'b00011_0010_0;
    localparam logic [9:0] C_DIVS = 10'b00011_0010_1;
    localparam logic [9:0] C_BR   = 10'b11111_1100_0;
    localparam logic [9:0] C_LU   = 10'b00111_0100_0;

    logic [9:0] got_ctrl;
    assign got_ctrl = {PC_EN, IF_ID_EN, ID_EX_EN, EX_MA_EN, MA_WB_EN,
                       IF_ID_FLUSH, ID_EX_FLUSH, EX_MA_FLUSH, MA_WB_FLUSH, DIV_START};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference model: divide-in-progress flag with remaining wait cycles,
    // memory-wait flag, and a saturating stall tally.
    bit         chk_en = 1'b0;
    bit         m_div = 1'b0, m_mem = 1'b0;
    int         m_left = 0;
    longint     m_stalls = 0;
    logic [9:0] e_ctrl;
    logic [1:0] e_state;
    bit         ms, lu;

    always @(negedge CLK) begin
        if (chk_en) begin
            if (RESET) begin
                m_div = 0; m_mem = 0; m_left = 0; m_stalls = 0;
            end
            ms = MA_MEM_REQ && !MEM_READY;
            lu = (EX_MR != 0) && EX_REG_EN && (EX_RD != 0) &&
                 ((ID_USES_RS1 && ID_RS1 == EX_RD) || (ID_USES_RS2 && ID_RS2 == EX_RD));
            if (ms)                  e_ctrl = C_MEM;
            else if (m_div)          e_ctrl = (m_left > 0) ? C_HOLD : C_NORM;
            else if (EX_IS_DIV)      e_ctrl = C_DIVS;
            else if (EX_BRANCH_TAKEN) e_ctrl = C_BR;
            else if (lu)             e_ctrl = C_LU;
            else                     e_ctrl = C_NORM;
            e_state = m_div ? 2'd1 : (m_mem ? 2'd2 : 2'd0);
            check("ctrl", {22'd0, got_ctrl}, {22'd0, e_ctrl});
            check("state", {30'd0, STATE}, {30'd0, e_state});
            check("stall_cnt", STALL_CNT, m_stalls[31:0]);
            if (!RESET) begin
                if (m_div) begin
                    if (m_left > 0) m_left--;
                    else if (!ms) m_div = 0;
                end else if (ms) begin
                    m_mem = 1;
                end else begin
                    m_mem = 0;
                    if (EX_IS_DIV) begin m_div = 1; m_left = 31; end
                end
                if (!e_ctrl[9] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
            end
        end
    end

    task automatic next_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ID_RS1 = 0; ID_RS2 = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
        EX_RD = 0; EX_MR = 0; EX_REG_EN = 0; EX_BRANCH_TAKEN = 0;
        EX_IS_DIV = 0; MA_MEM_REQ = 0; MEM_READY = 0;
    endtask

    task automatic set_load_use();
        EX_MR = 2'd1; EX_RD = 5'd5; EX_REG_EN = 1; ID_RS2 = 5'd5; ID_USES_RS2 = 1;
    endtask

    int n_start, n_flush, n_state1;

    initial begin
        RESET = 1;
        clear_inputs();
        chk_en = 1;
        repeat (2) next_edge();
        @(negedge CLK);
        check("reset_state", {30'd0, STATE}, 32'd0);
        check("reset_stall", STALL_CNT, 32'd0);
        next_edge();
        RESET = 0;
        next_edge();

        // Load-use: one frozen cycle with an ID/EX bubble.
        set_load_use();
        @(negedge CLK);
        check("lu_pc_en", {31'd0, PC_EN}, 32'd0);
        check("lu_if_id_en", {31'd0, IF_ID_EN}, 32'd0);
        check("lu_id_ex_flush", {31'd0, ID_EX_FLUSH}, 32'd1);
        next_edge();
        clear_inputs();
        @(negedge CLK);
        check("lu_stall_cnt", STALL_CNT, 32'd1);

        // No hazard through x0 or through an unused source.
        next_edge();
        set_load_use(); EX_RD = 5'd0;
        @(negedge CLK);
        check("lu_rd0_normal", {22'd0, got_ctrl}, {22'd0, C_NORM});
        next_edge();
        set_load_use(); ID_USES_RS2 = 0;
        @(negedge CLK);
        check("lu_unused_normal", {22'd0, got_ctrl}, {22'd0, C_NORM});

        // Branch masks a coincident load-use.
        next_edge();
        set_load_use(); EX_BRANCH_TAKEN = 1;
        @(negedge CLK);
        check("br_lu_ctrl", {22'd0, got_ctrl}, {22'd0, C_BR});
        next_edge();
        clear_inputs();

        // Memory wait for three cycles, then ready.
        for (int i = 0; i < 3; i++) begin
            MA_MEM_REQ = 1; MEM_READY = 0;
            @(negedge CLK);
            check("mem_ctrl", {22'd0, got_ctrl}, {22'd0, C_MEM});
            check("mem_state", {30'd0, STATE}, (i == 0) ? 32'd0 : 32'd2);
            next_edge();
        end
        MEM_READY = 1;
        @(negedge CLK);
        check("mem_ready_ctrl", {22'd0, got_ctrl}, {22'd0, C_NORM});
        check("mem_ready_state", {30'd0, STATE}, 32'd2);
        next_edge();
        clear_inputs();
        @(negedge CLK);
        check("mem_done_state", {30'd0, STATE}, 32'd0);
        check("mem_stall_cnt", STALL_CNT, 32'd4);

        // Plain divide: 32 frozen cycles, then capture.
        next_edge();
        EX_IS_DIV = 1;
        n_start = 0; n_flush = 0; n_state1 = 0;
        for (int i = 0; i < 33; i++) begin
            @(negedge CLK);
            n_start  += DIV_START;
            n_flush  += EX_MA_FLUSH;
            n_state1 += (STATE == 2'd1);
            if (i == 32) begin
                check("div_capture_ctrl", {22'd0, got_ctrl}, {22'd0, C_NORM});
                check("div_capture_state", {30'd0, STATE}, 32'd1);
            end
            next_edge();
        end
        EX_IS_DIV = 0;
        @(negedge CLK);
        check("div_starts", n_start, 32'd1);
        check("div_flushes", n_flush, 32'd32);
        check("div_state1", n_state1, 32'd32);
        check("div_done_state", {30'd0, STATE}, 32'd0);
        check("div_stall_cnt", STALL_CNT, 32'd36);

        // Divide whose capture is delayed by two memory-stall cycles.
        next_edge();
        EX_IS_DIV = 1;
        repeat (32) next_edge();
        for (int i = 0; i < 2; i++) begin
            MA_MEM_REQ = 1; MEM_READY = 0;
            @(negedge CLK);
            check("divmem_ctrl", {22'd0, got_ctrl}, {22'd0, C_MEM});
            check("divmem_state", {30'd0, STATE}, 32'd1);
            next_edge();
        end
        MEM_READY = 1;
        @(negedge CLK);
        check("divmem_capture_ctrl", {22'd0, got_ctrl}, {22'd0, C_NORM});
        check("divmem_capture_state", {30'd0, STATE}, 32'd1);
        next_edge();
        clear_inputs();
        @(negedge CLK);
        check("divmem_done_state", {30'd0, STATE}, 32'd0);
        check("divmem_stall_cnt", STALL_CNT, 32'd70);

        // Reset arriving while the divide counter sits at 10.
        next_edge();
        EX_IS_DIV = 1;
        repeat (22) next_edge();
        RESET = 1; EX_IS_DIV = 0;
        @(negedge CLK);
        check("rst_div_state", {30'd0, STATE}, 32'd0);
        check("rst_div_stall", STALL_CNT, 32'd0);
        check("rst_div_start", {31'd0, DIV_START}, 32'd0);
        next_edge();
        RESET = 0;
        n_start = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_start += DIV_START;
            next_edge();
        end
        check("rst_div_no_replay", n_start, 32'd0);

        // Random traffic; the model checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            RESET           = ($urandom_range(0, 399) == 0);
            ID_RS1          = 5'($urandom_range(0, 3));
            ID_RS2          = 5'($urandom_range(0, 3));
            ID_USES_RS1     = 1'($urandom_range(0, 1));
            ID_USES_RS2     = 1'($urandom_range(0, 1));
            EX_RD           = 5'($urandom_range(0, 3));
            EX_MR           = 2'($urandom_range(0, 3));
            EX_REG_EN       = 1'($urandom_range(0, 1));
            EX_BRANCH_TAKEN = ($urandom_range(0, 7) == 0);
            EX_IS_DIV       = ($urandom_range(0, 49) == 0);
            MA_MEM_REQ      = ($urandom_range(0, 2) == 0);
            MEM_READY       = 1'($urandom_range(0, 1));
            next_edge();
        end
        RESET = 0;
        clear_inputs();
        next_edge();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
